// File: rtl/array_16_access_ctrl.sv
// array_16_access_ctrl: single-port front-end for the 1024x2112 masked SRAM.
// Merges read and write request streams onto one RW port. Writes are buffered
// in a 2-entry FIFO. A read waits while the FIFO holds a write to its row.
// Read data goes out through a ready/valid channel that has a 1-entry skid.
module array_16_access_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned SEGS   = 16,
  parameter int unsigned SEG_W  = 132,
  localparam int unsigned DATA_W = SEGS * SEG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_r_req_valid,
  output logic              io_r_req_ready,
  input  logic [ADDR_W-1:0] io_r_req_addr,
  output logic              io_r_resp_valid,
  input  logic              io_r_resp_ready,
  output logic [DATA_W-1:0] io_r_resp_data,
  input  logic              io_w_req_valid,
  output logic              io_w_req_ready,
  input  logic [ADDR_W-1:0] io_w_req_addr,
  input  logic [SEGS-1:0]   io_w_req_mask,
  input  logic [DATA_W-1:0] io_w_req_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [SEGS-1:0]   sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SEGS-1:0]   mask;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t         fifo_q [2];
  logic              head_q;
  logic [1:0]        count_q;
  logic              inflight_q;
  logic              hold_valid_q;
  logic [DATA_W-1:0] hold_data_q;

  logic      full;
  logic      empty;
  logic [1:0] ent_vld;
  logic      hz;
  logic      rslot_free;
  logic      rd_sel;
  logic      wr_sel;
  logic      wr_go;
  logic      enq;
  logic      tail;
  wb_entry_t head;

  // Arbitration: a read goes first unless it has a hazard, the response slot is busy, or the FIFO is full.
  always_comb begin
    full       = (count_q == 2'd2);
    empty      = (count_q == 2'd0);
    ent_vld[0] = full || ((count_q == 2'd1) && !head_q);
    ent_vld[1] = full || ((count_q == 2'd1) && head_q);
    hz         = io_r_req_valid &&
                 ((ent_vld[0] && (fifo_q[0].addr == io_r_req_addr)) ||
                  (ent_vld[1] && (fifo_q[1].addr == io_r_req_addr)));
    rslot_free = !hold_valid_q && !(inflight_q && !io_r_resp_ready);
    rd_sel     = !reset && io_r_req_valid && rslot_free && !hz && !full;
    wr_sel     = !reset && !rd_sel && !empty;
    head       = fifo_q[head_q];
    wr_go      = wr_sel && (|head.mask);
    enq        = !reset && io_w_req_valid && !full;
    tail       = head_q ^ count_q[0];
  end

  // SRAM port and handshake outputs. When the port is not in use it drives all zeros.
  always_comb begin
    sram_en         = 1'b0;
    sram_wmode      = 1'b0;
    sram_addr       = '0;
    sram_wmask      = '0;
    sram_wdata      = '0;
    io_r_req_ready  = rd_sel;
    io_w_req_ready  = !reset && !full;
    io_r_resp_valid = 1'b0;
    io_r_resp_data  = '0;
    if (rd_sel) begin
      sram_en   = 1'b1;
      sram_addr = io_r_req_addr;
    end else if (wr_go) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = head.addr;
      sram_wmask = head.mask;
      sram_wdata = head.data;
    end
    if (!reset) begin
      if (hold_valid_q) begin
        io_r_resp_valid = 1'b1;
        io_r_resp_data  = hold_data_q;
      end else if (inflight_q) begin
        io_r_resp_valid = 1'b1;
        io_r_resp_data  = sram_rdata;
      end
    end
  end

  // Write FIFO storage. Entries are not reset because occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (enq) begin
      fifo_q[tail] <= '{addr: io_w_req_addr, mask: io_w_req_mask, data: io_w_req_data};
    end
  end

  // FIFO pointers, read-in-flight flag and response skid buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q       <= 1'b0;
      count_q      <= 2'd0;
      inflight_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      head_q     <= head_q ^ wr_sel;
      count_q    <= count_q + 2'(enq) - 2'(wr_sel);
      inflight_q <= rd_sel;
      if (hold_valid_q) begin
        if (io_r_resp_ready) hold_valid_q <= 1'b0;
      end else if (inflight_q && !io_r_resp_ready) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_array_16_access_ctrl.sv
// Testbench for array_16_access_ctrl. It runs a table of directed cycles, a
// mid-stream reset, and a random phase checked against a golden memory model.
module tb_array_16_access_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned SEGS   = 16;
  localparam int unsigned SEG_W  = 132;
  localparam int unsigned DATA_W = SEGS * SEG_W;
  localparam int unsigned WORDS  = DATA_W / 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              io_r_req_valid = 1'b0;
  logic              io_r_req_ready;
  logic [ADDR_W-1:0] io_r_req_addr = '0;
  logic              io_r_resp_valid;
  logic              io_r_resp_ready = 1'b0;
  logic [DATA_W-1:0] io_r_resp_data;
  logic              io_w_req_valid = 1'b0;
  logic              io_w_req_ready;
  logic [ADDR_W-1:0] io_w_req_addr = '0;
  logic [SEGS-1:0]   io_w_req_mask = '0;
  logic [DATA_W-1:0] io_w_req_data = '0;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [SEGS-1:0]   sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;

  array_16_access_ctrl dut (
    .clock(clock), .reset(reset),
    .io_r_req_valid(io_r_req_valid), .io_r_req_ready(io_r_req_ready), .io_r_req_addr(io_r_req_addr),
    .io_r_resp_valid(io_r_resp_valid), .io_r_resp_ready(io_r_resp_ready), .io_r_resp_data(io_r_resp_data),
    .io_w_req_valid(io_w_req_valid), .io_w_req_ready(io_w_req_ready), .io_w_req_addr(io_w_req_addr),
    .io_w_req_mask(io_w_req_mask), .io_w_req_data(io_w_req_data),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  // SRAM model. Data read out is valid for one cycle only; on any other cycle the model drives a poison value.
  localparam logic [DATA_W-1:0] POISON = {66{32'hDEADBEEF}};
  bit [DATA_W-1:0] sram_mem [1024];
  always @(posedge clock) begin
    if (sram_en && sram_wmode) begin
      for (int s = 0; s < SEGS; s++)
        if (sram_wmask[s]) sram_mem[sram_addr][s*SEG_W +: SEG_W] <= sram_wdata[s*SEG_W +: SEG_W];
      sram_rdata <= POISON;
    end else if (sram_en) begin
      sram_rdata <= sram_mem[sram_addr];
    end else begin
      sram_rdata <= POISON;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [DATA_W-1:0] mkpat(input int unsigned s);
    logic [DATA_W-1:0] p;
    for (int i = 0; i < WORDS; i++) p[i*32 +: 32] = (s * 32'h9E3779B9) + (i * 32'h3C6EF372) ^ 32'h55AA00FF;
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] rnddata();
    logic [DATA_W-1:0] p;
    for (int i = 0; i < WORDS; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] apply_mask(input logic [DATA_W-1:0] old,
                                                   input logic [SEGS-1:0] m,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = old;
    for (int s = 0; s < SEGS; s++) if (m[s]) r[s*SEG_W +: SEG_W] = d[s*SEG_W +: SEG_W];
    return r;
  endfunction

  function automatic bit outs_zero();
    return !io_r_req_ready && !io_w_req_ready && !io_r_resp_valid && (io_r_resp_data == '0) &&
           !sram_en && !sram_wmode && (sram_addr == '0) && (sram_wmask == '0) && (sram_wdata == '0);
  endfunction

  typedef struct {
    logic              rv;
    logic [ADDR_W-1:0] ra;
    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic [SEGS-1:0]   wm;
    int                wd;
    logic              rr;
    logic              e_rrdy, e_wrdy, e_en, e_wmode;
    logic [ADDR_W-1:0] e_addr;
    logic [SEGS-1:0]   e_wmask;
    logic              e_rsv;
    int                e_pat;
  } vec_t;

  vec_t tbl[$];
  logic [DATA_W-1:0] pat [5];

  task automatic add(input logic rv, input int ra, input logic wv, input int wa, input logic [15:0] wm,
                     input int wd, input logic rr, input logic rrdy, input logic wrdy, input logic en,
                     input logic wmode, input int addr, input logic [15:0] wmask, input logic rsv,
                     input int epat);
    vec_t v;
    v.rv = rv; v.ra = ADDR_W'(ra); v.wv = wv; v.wa = ADDR_W'(wa); v.wm = wm; v.wd = wd; v.rr = rr;
    v.e_rrdy = rrdy; v.e_wrdy = wrdy; v.e_en = en; v.e_wmode = wmode; v.e_addr = ADDR_W'(addr);
    v.e_wmask = wmask; v.e_rsv = rsv; v.e_pat = epat;
    tbl.push_back(v);
  endtask

  // Golden memory for the random phase: a read sees every write accepted in an earlier cycle.
  bit [DATA_W-1:0]   gold [int];
  logic [DATA_W-1:0] exp_q [$];

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] e;
    pat[0] = '0;
    pat[1] = mkpat(1);
    pat[2] = mkpat(2);
    pat[3] = mkpat(3);
    pat[4] = apply_mask('0, 16'h0001, pat[3]);

    // Directed cycles: rv ra wv wa wm wd rr | rrdy wrdy en wmode addr wmask rsv pat
    add(0,0,  1,5,16'hFFFF,1, 1,  0,1,0,0,0,0,            0,-1);
    add(1,5,  0,0,0,0,     1,  0,1,1,1,5,16'hFFFF,      0,-1);
    add(1,5,  0,0,0,0,     1,  1,1,1,0,5,0,             0,-1);
    add(0,0,  0,0,0,0,     1,  0,1,0,0,0,0,             1,1);
    add(1,5,  1,5,16'hFFFF,2, 1,  1,1,1,0,5,0,          0,-1);
    add(1,5,  0,0,0,0,     1,  0,1,1,1,5,16'hFFFF,      1,1);
    add(1,5,  0,0,0,0,     1,  1,1,1,0,5,0,             0,-1);
    add(1,1,  0,0,0,0,     1,  1,1,1,0,1,0,             1,2);
    add(1,2,  0,0,0,0,     1,  1,1,1,0,2,0,             1,0);
    add(1,3,  0,0,0,0,     1,  1,1,1,0,3,0,             1,0);
    add(0,0,  0,0,0,0,     1,  0,1,0,0,0,0,             1,0);
    add(1,5,  0,0,0,0,     0,  1,1,1,0,5,0,             0,-1);
    add(1,1,  0,0,0,0,     0,  0,1,0,0,0,0,             1,2);
    add(1,1,  0,0,0,0,     0,  0,1,0,0,0,0,             1,2);
    add(1,1,  0,0,0,0,     0,  0,1,0,0,0,0,             1,2);
    add(1,1,  0,0,0,0,     1,  0,1,0,0,0,0,             1,2);
    add(1,1,  0,0,0,0,     1,  1,1,1,0,1,0,             0,-1);
    add(0,0,  0,0,0,0,     1,  0,1,0,0,0,0,             1,0);
    add(1,0,  1,8,16'hFFFF,1, 1,  1,1,1,0,0,0,          0,-1);
    add(1,0,  1,9,16'hFFFF,2, 1,  1,1,1,0,0,0,          1,0);
    add(1,0,  1,10,16'hFFFF,3, 1, 0,0,1,1,8,16'hFFFF,   1,0);
    add(1,0,  1,10,16'hFFFF,3, 1, 1,1,1,0,0,0,          0,-1);
    add(1,0,  0,0,0,0,     1,  0,0,1,1,9,16'hFFFF,      1,0);
    add(1,0,  0,0,0,0,     1,  1,1,1,0,0,0,             0,-1);
    add(0,0,  0,0,0,0,     1,  0,1,1,1,10,16'hFFFF,     1,0);
    add(0,0,  1,12,16'h0001,3, 1, 0,1,0,0,0,0,          0,-1);
    add(0,0,  0,0,0,0,     1,  0,1,1,1,12,16'h0001,     0,-1);
    add(1,12, 0,0,0,0,     1,  1,1,1,0,12,0,            0,-1);
    add(1,8,  0,0,0,0,     1,  1,1,1,0,8,0,             1,4);
    add(1,9,  0,0,0,0,     1,  1,1,1,0,9,0,             1,1);
    add(1,10, 0,0,0,0,     1,  1,1,1,0,10,0,            1,2);
    add(0,0,  0,0,0,0,     1,  0,1,0,0,0,0,             1,3);
    add(0,0,  1,13,16'h0000,1, 1, 0,1,0,0,0,0,          0,-1);
    add(0,0,  0,0,0,0,     1,  0,1,0,0,0,0,             0,-1);
    add(1,13, 0,0,0,0,     1,  1,1,1,0,13,0,            0,-1);
    add(0,0,  0,0,0,0,     1,  0,1,0,0,0,0,             1,0);

    // Reset state: drive active requests while reset is held; every output must stay 0.
    io_r_req_valid = 1'b1; io_w_req_valid = 1'b1; io_w_req_mask = '1; io_r_resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check(outs_zero(), "reset_outputs", $sformatf("rrdy=%0b wrdy=%0b rsv=%0b en=%0b, required all 0",
          io_r_req_ready, io_w_req_ready, io_r_resp_valid, sram_en));
    io_r_req_valid = 1'b0; io_w_req_valid = 1'b0; io_w_req_mask = '0;
    @(posedge clock); #1 reset = 1'b0;

    // Apply the directed table, one vector per cycle.
    foreach (tbl[i]) begin
      io_r_req_valid = tbl[i].rv; io_r_req_addr = tbl[i].ra;
      io_w_req_valid = tbl[i].wv; io_w_req_addr = tbl[i].wa; io_w_req_mask = tbl[i].wm;
      io_w_req_data = pat[tbl[i].wd]; io_r_resp_ready = tbl[i].rr;
      @(negedge clock);
      check({io_r_req_ready, io_w_req_ready, sram_en, sram_wmode, sram_addr, sram_wmask, io_r_resp_valid} ==
            {tbl[i].e_rrdy, tbl[i].e_wrdy, tbl[i].e_en, tbl[i].e_wmode, tbl[i].e_addr, tbl[i].e_wmask, tbl[i].e_rsv},
            $sformatf("vec%0d_ctrl", i),
            $sformatf("got rrdy=%0b wrdy=%0b en=%0b wm=%0b addr=%0d mask=%h rsv=%0b, required %0b %0b %0b %0b %0d %h %0b",
            io_r_req_ready, io_w_req_ready, sram_en, sram_wmode, sram_addr, sram_wmask, io_r_resp_valid,
            tbl[i].e_rrdy, tbl[i].e_wrdy, tbl[i].e_en, tbl[i].e_wmode, tbl[i].e_addr, tbl[i].e_wmask, tbl[i].e_rsv));
      if (tbl[i].e_pat >= 0) begin
        e = pat[tbl[i].e_pat];
        check(io_r_resp_data == e, $sformatf("vec%0d_data", i),
              $sformatf("got low64=%h, required low64=%h", io_r_resp_data[63:0], e[63:0]));
      end
      @(posedge clock); #1;
    end

    // Mid-stream reset: a write is queued and a read is in flight when reset is asserted.
    io_r_req_valid = 1'b1; io_r_req_addr = 10'd30;
    io_w_req_valid = 1'b1; io_w_req_addr = 10'd20; io_w_req_mask = '1; io_w_req_data = pat[1];
    io_r_resp_ready = 1'b1;
    @(posedge clock); #1;
    io_r_req_valid = 1'b0; io_w_req_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check(outs_zero(), "async_reset_outputs", $sformatf("rrdy=%0b wrdy=%0b rsv=%0b en=%0b wmode=%0b addr=%0d, required all 0",
             io_r_req_ready, io_w_req_ready, io_r_resp_valid, sram_en, sram_wmode, sram_addr));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check(io_w_req_ready && !io_r_resp_valid && !sram_en, "post_reset_cleared",
          $sformatf("wrdy=%0b rsv=%0b en=%0b, required 1 0 0", io_w_req_ready, io_r_resp_valid, sram_en));
    @(posedge clock); #1;
    io_r_req_valid = 1'b1; io_r_req_addr = 10'd20;
    @(negedge clock);
    check(io_r_req_ready, "post_reset_read_ready", $sformatf("rrdy=%0b, required 1", io_r_req_ready));
    @(posedge clock); #1 io_r_req_valid = 1'b0;
    @(negedge clock);
    check(io_r_resp_valid && (io_r_resp_data == '0), "post_reset_row20",
          $sformatf("rsv=%0b low64=%h, required rsv=1 data=0", io_r_resp_valid, io_r_resp_data[63:0]));
    @(posedge clock); #1;

    // Random phase on rows 40..43, none of which has been written before.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      io_r_req_valid  = ($urandom_range(3) != 0);
      io_r_req_addr   = ADDR_W'(40 + $urandom_range(3));
      io_w_req_valid  = ($urandom_range(2) == 0);
      io_w_req_addr   = ADDR_W'(40 + $urandom_range(3));
      case ($urandom_range(3))
        0: io_w_req_mask = '0;
        1: io_w_req_mask = '1;
        default: io_w_req_mask = SEGS'($urandom());
      endcase
      io_w_req_data   = rnddata();
      io_r_resp_ready = ($urandom_range(3) != 0);
      @(negedge clock);
      if (io_r_resp_valid && io_r_resp_ready) begin
        check(exp_q.size() > 0, "rnd_spurious_resp", "got resp_valid, required no pending read");
        if (exp_q.size() > 0) begin
          d = exp_q.pop_front();
          check(io_r_resp_data == d, $sformatf("rnd_resp_c%0d", cyc),
                $sformatf("got low64=%h, required low64=%h", io_r_resp_data[63:0], d[63:0]));
        end
      end
      if (io_r_req_valid && io_r_req_ready) exp_q.push_back(gold[int'(io_r_req_addr)]);
      if (io_w_req_valid && io_w_req_ready)
        gold[int'(io_w_req_addr)] = apply_mask(gold[int'(io_w_req_addr)], io_w_req_mask, io_w_req_data);
      @(posedge clock); #1;
    end

    // Drain with a bounded cycle budget, then compare the final SRAM contents with the golden memory.
    io_r_req_valid = 1'b0; io_w_req_valid = 1'b0; io_r_resp_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      if (io_r_resp_valid && exp_q.size() > 0) begin
        d = exp_q.pop_front();
        check(io_r_resp_data == d, "drain_resp",
              $sformatf("got low64=%h, required low64=%h", io_r_resp_data[63:0], d[63:0]));
      end
      @(posedge clock); #1;
    end
    check(exp_q.size() == 0, "drain_all_returned", $sformatf("%0d reads outstanding, required 0", exp_q.size()));
    for (int a = 40; a < 44; a++) begin
      d = sram_mem[a];
      e = gold[a];
      check(d == e, $sformatf("final_row%0d", a), $sformatf("got low64=%h, required low64=%h", d[63:0], e[63:0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
